exu_trap: RTL and testbench

- Trap sequencer that sits directly upstream of the execute-stage CSR file.
- Watches the commit slot and the interrupt lines, and decides when a trap or an mret takes effect.
- Drives the CSR file's trap/mret strobes (int_ena, i_mcause, epc_pc, mret_ena) and its retire strobe (in_retr).
- Issues a flush/redirect to the fetch unit, targeting cmtvec or cmepc as supplied by the CSR file.

---
 rtl/exu_trap_pkg.sv | 24 ++
 rtl/exu_trap_if.sv | 47 ++++
 rtl/exu_trap_prio.sv | 46 ++++
 rtl/exu_trap.sv | 177 +++++++++++++++++
 tb/tb_exu_trap.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exu_trap_pkg.sv
// Shared definitions for the exu_trap slice: FSM state encoding, mcause constants,
// and the interrupt-line bundle type.
package exu_trap_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRAIN = 3'd1;
  localparam logic [2:0] ST_TRAP  = 3'd2;
  localparam logic [2:0] ST_MRET  = 3'd3;
  localparam logic [2:0] ST_REDIR = 3'd4;

  localparam logic [31:0] CAUSE_ILGL  = 32'd2;
  localparam logic [31:0] CAUSE_BRK   = 32'd3;
  localparam logic [31:0] CAUSE_ECALL = 32'd11;
  localparam logic [31:0] CAUSE_MEI   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI   = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI   = 32'h8000_0007;

  typedef struct packed {
    logic ext;
    logic sft;
    logic tmr;
  } irq_t;

endpackage

// File: rtl/exu_trap_if.sv
// Commit-slot, CSR-file and fetch-redirect signals of the trap sequencer.
// The slave modport is the sequencer's view; master is the surrounding pipeline.
interface exu_trap_if;
  logic        cmt_valid;
  logic [31:0] cmt_pc;
  logic        cmt_ecall;
  logic        cmt_ebreak;
  logic        cmt_ilgl;
  logic        cmt_mret;
  logic        cmt_kill;
  logic        in_retr;
  logic        ext_ip;
  logic        tmr_ip;
  logic        sft_ip;
  logic        mstatus_mie;
  logic        meie;
  logic        mtie;
  logic        msie;
  logic        lsu_idle;
  logic [31:0] cmtvec;
  logic [31:0] cmepc;
  logic        int_ena;
  logic [31:0] i_mcause;
  logic [31:0] epc_pc;
  logic        mret_ena;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;
  logic        stall;
  logic        drain_to_err;

  modport slave (
    input  cmt_valid, cmt_pc, cmt_ecall, cmt_ebreak, cmt_ilgl, cmt_mret,
    input  ext_ip, tmr_ip, sft_ip, mstatus_mie, meie, mtie, msie,
    input  lsu_idle, cmtvec, cmepc, redir_ready,
    output cmt_kill, in_retr, int_ena, i_mcause, epc_pc, mret_ena,
    output redir_valid, redir_pc, stall, drain_to_err
  );

  modport master (
    output cmt_valid, cmt_pc, cmt_ecall, cmt_ebreak, cmt_ilgl, cmt_mret,
    output ext_ip, tmr_ip, sft_ip, mstatus_mie, meie, mtie, msie,
    output lsu_idle, cmtvec, cmepc, redir_ready,
    input  cmt_kill, in_retr, int_ena, i_mcause, epc_pc, mret_ena,
    input  redir_valid, redir_pc, stall, drain_to_err
  );
endinterface

// File: rtl/exu_trap_prio.sv
// Combinational trap priority encoder: exceptions beat mret, mret beats interrupts,
// and interrupts rank MEI > MSI > MTI.
module exu_trap_prio
  import exu_trap_pkg::*;
(
  input  logic        ilgl,
  input  logic        ebreak,
  input  logic        ecall,
  input  logic        mret,
  input  logic        mie,
  input  irq_t        ip,
  input  irq_t        ie,
  output logic        trap_evt,
  output logic        mret_evt,
  output logic [31:0] cause
);

  irq_t act_s;
  logic excp_s;
  logic int_pend_s;

  assign act_s      = irq_t'(ip & ie);
  assign excp_s     = ilgl | ebreak | ecall;
  assign int_pend_s = mie & (act_s.ext | act_s.sft | act_s.tmr);
  assign trap_evt   = excp_s | (int_pend_s & ~mret);
  assign mret_evt   = mret & ~excp_s;

  // Cause selection in fixed priority order.
  always_comb begin
    cause = CAUSE_MTI;
    if (ilgl) begin
      cause = CAUSE_ILGL;
    end else if (ebreak) begin
      cause = CAUSE_BRK;
    end else if (ecall) begin
      cause = CAUSE_ECALL;
    end else if (act_s.ext) begin
      cause = CAUSE_MEI;
    end else if (act_s.sft) begin
      cause = CAUSE_MSI;
    end else begin
      cause = CAUSE_MTI;
    end
  end

endmodule

// File: rtl/exu_trap.sv
// Trap sequencer ahead of the execute-stage CSR file: trap entry, mret and fetch redirect.
// Build macro EXCP_VECTORED_EN enables vectored interrupt targets when cmtvec[1:0]==2'b01.
module exu_trap
  import exu_trap_pkg::*;
#(
  parameter int unsigned DRAIN_TO = 32'd255
) (
  input logic       clk,
  input logic       rst_n,
  exu_trap_if.slave bus
);

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TO - 32'd1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        int_ena_q, int_ena_d;
  logic        mret_ena_q, mret_ena_d;
  logic        redir_valid_q, redir_valid_d;
  logic        stall_q, stall_d;
  logic        drain_to_err_q, drain_to_err_d;
  logic [31:0] i_mcause_q, i_mcause_d;
  logic [31:0] epc_pc_q, epc_pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic        kill_s;
  logic        retr_s;
  logic        timeout_s;
  logic        trap_evt_s;
  logic        mret_evt_s;
  logic [31:0] prio_cause_s;
  logic [31:0] tvec_base_s;
  logic [31:0] trap_tgt_s;
  irq_t        ip_s;
  irq_t        ie_s;

  assign ip_s = '{ext: bus.ext_ip, sft: bus.sft_ip, tmr: bus.tmr_ip};
  assign ie_s = '{ext: bus.meie,   sft: bus.msie,   tmr: bus.mtie};

  exu_trap_prio u_prio (
    .ilgl     (bus.cmt_ilgl),
    .ebreak   (bus.cmt_ebreak),
    .ecall    (bus.cmt_ecall),
    .mret     (bus.cmt_mret),
    .mie      (bus.mstatus_mie),
    .ip       (ip_s),
    .ie       (ie_s),
    .trap_evt (trap_evt_s),
    .mret_evt (mret_evt_s),
    .cause    (prio_cause_s)
  );

  assign tvec_base_s = {bus.cmtvec[31:2], 2'b00};

`ifdef EXCP_VECTORED_EN
  // Interrupts in vectored mode land on base + 4*code; exceptions always use the base.
  assign trap_tgt_s = (bus.cmtvec[1:0] == 2'b01 && cause_q[31])
                    ? tvec_base_s + {25'd0, cause_q[4:0], 2'b00}
                    : tvec_base_s;
`else
  logic unused_mode_s;
  assign unused_mode_s = ^bus.cmtvec[1:0];
  assign trap_tgt_s    = tvec_base_s;
`endif

  // Next-state logic and the commit-slot kill/retire decision.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    kill_s    = 1'b0;
    retr_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmt_valid) begin
          if (trap_evt_s) begin
            kill_s  = 1'b1;
            cause_d = prio_cause_s;
            epc_d   = bus.cmt_pc;
            cnt_d   = 8'd0;
            state_d = bus.lsu_idle ? ST_TRAP : ST_DRAIN;
          end else if (mret_evt_s) begin
            retr_s  = 1'b1;
            state_d = ST_MRET;
          end else begin
            retr_s  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (bus.lsu_idle) begin
          state_d = ST_TRAP;
        end else if (cnt_q == DRAIN_LAST) begin
          timeout_s = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_TRAP:  state_d = ST_REDIR;
      ST_MRET:  state_d = ST_REDIR;
      ST_REDIR: begin
        if (bus.redir_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REDIR;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes follow the next state so each lines up with the cycle its state is held.
  always_comb begin
    int_ena_d      = (state_d == ST_TRAP);
    mret_ena_d     = (state_d == ST_MRET);
    redir_valid_d  = (state_d == ST_REDIR);
    stall_d        = (state_d != ST_IDLE);
    drain_to_err_d = timeout_s;
    i_mcause_d     = (state_d == ST_TRAP) ? cause_d : i_mcause_q;
    epc_pc_d       = (state_d == ST_TRAP) ? epc_d : epc_pc_q;
    case (state_q)
      ST_TRAP: redir_pc_d = trap_tgt_s;
      ST_MRET: redir_pc_d = bus.cmepc;
      default: redir_pc_d = redir_pc_q;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 8'd0;
      cause_q        <= 32'd0;
      epc_q          <= 32'd0;
      int_ena_q      <= 1'b0;
      mret_ena_q     <= 1'b0;
      redir_valid_q  <= 1'b0;
      stall_q        <= 1'b0;
      drain_to_err_q <= 1'b0;
      i_mcause_q     <= 32'd0;
      epc_pc_q       <= 32'd0;
      redir_pc_q     <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cause_q        <= cause_d;
      epc_q          <= epc_d;
      int_ena_q      <= int_ena_d;
      mret_ena_q     <= mret_ena_d;
      redir_valid_q  <= redir_valid_d;
      stall_q        <= stall_d;
      drain_to_err_q <= drain_to_err_d;
      i_mcause_q     <= i_mcause_d;
      epc_pc_q       <= epc_pc_d;
      redir_pc_q     <= redir_pc_d;
    end
  end

  assign bus.cmt_kill     = kill_s;
  assign bus.in_retr      = retr_s;
  assign bus.int_ena      = int_ena_q;
  assign bus.mret_ena     = mret_ena_q;
  assign bus.redir_valid  = redir_valid_q;
  assign bus.redir_pc     = redir_pc_q;
  assign bus.stall        = stall_q;
  assign bus.drain_to_err = drain_to_err_q;
  assign bus.i_mcause     = i_mcause_q;
  assign bus.epc_pc       = epc_pc_q;

endmodule

// File: tb/tb_exu_trap.sv
// Self-checking bench for exu_trap: directed scenarios plus randomized commit traffic
// checked against a transaction-level model of the trap rules.
module tb_exu_trap;

  logic clk = 1'b0;
  logic rst_n;
  logic sel4;
  int   checks;
  int   failures;
  logic [31:0] exp_cause;
  logic [31:0] exp_epc;

  always #5 clk = ~clk;

  exu_trap_if if0 ();
  exu_trap_if if4 ();

  exu_trap #(.DRAIN_TO(255)) dut  (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  exu_trap #(.DRAIN_TO(4))   dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  assign if4.cmt_valid   = if0.cmt_valid;
  assign if4.cmt_pc      = if0.cmt_pc;
  assign if4.cmt_ecall   = if0.cmt_ecall;
  assign if4.cmt_ebreak  = if0.cmt_ebreak;
  assign if4.cmt_ilgl    = if0.cmt_ilgl;
  assign if4.cmt_mret    = if0.cmt_mret;
  assign if4.ext_ip      = if0.ext_ip;
  assign if4.tmr_ip      = if0.tmr_ip;
  assign if4.sft_ip      = if0.sft_ip;
  assign if4.mstatus_mie = if0.mstatus_mie;
  assign if4.meie        = if0.meie;
  assign if4.mtie        = if0.mtie;
  assign if4.msie        = if0.msie;
  assign if4.lsu_idle    = if0.lsu_idle;
  assign if4.cmtvec      = if0.cmtvec;
  assign if4.cmepc       = if0.cmepc;
  assign if4.redir_ready = if0.redir_ready;

  // ctl = {cmt_kill, in_retr, stall, int_ena, mret_ena, redir_valid, drain_to_err}
  logic [6:0]  ctl;
  logic [31:0] o_cause, o_epc, o_rpc;
  always_comb begin
    if (sel4) begin
      ctl = {if4.cmt_kill, if4.in_retr, if4.stall, if4.int_ena, if4.mret_ena, if4.redir_valid, if4.drain_to_err};
      o_cause = if4.i_mcause; o_epc = if4.epc_pc; o_rpc = if4.redir_pc;
    end else begin
      ctl = {if0.cmt_kill, if0.in_retr, if0.stall, if0.int_ena, if0.mret_ena, if0.redir_valid, if0.drain_to_err};
      o_cause = if0.i_mcause; o_epc = if0.epc_pc; o_rpc = if0.redir_pc;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    if0.cmt_valid = 1'b0; if0.cmt_pc = 32'd0;
    if0.cmt_ecall = 1'b0; if0.cmt_ebreak = 1'b0; if0.cmt_ilgl = 1'b0; if0.cmt_mret = 1'b0;
    if0.ext_ip = 1'b0; if0.tmr_ip = 1'b0; if0.sft_ip = 1'b0;
    if0.mstatus_mie = 1'b0; if0.meie = 1'b0; if0.mtie = 1'b0; if0.msie = 1'b0;
    if0.lsu_idle = 1'b1; if0.cmtvec = 32'd0; if0.cmepc = 32'd0; if0.redir_ready = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    exp_cause = 32'd0;
    exp_epc   = 32'd0;
  endtask

  // One commit-slot transaction, checked cycle by cycle against the trap rules.
  // fl = {ilgl, ebreak, ecall, mret}; ip = {ext, sft, tmr}; en = {mie, meie, msie, mtie}
  // busy = cycles lsu_idle stays low counting from the event cycle.
  task automatic run_txn(input logic valid, input logic [31:0] pc, input logic [3:0] fl,
                         input logic [2:0] ip, input logic [3:0] en, input logic [31:0] vec,
                         input logic [31:0] ret, input int busy, input int rdly);
    logic        exc, ipend, is_trap, is_mret, err;
    logic [31:0] cause, tgt;
    int          ndrain, dto;
    dto   = sel4 ? 4 : 255;
    exc   = fl[3] | fl[2] | fl[1];
    ipend = en[3] & ((ip[2] & en[2]) | (ip[1] & en[1]) | (ip[0] & en[0]));
    if (fl[3])               cause = 32'd2;
    else if (fl[2])          cause = 32'd3;
    else if (fl[1])          cause = 32'd11;
    else if (ip[2] & en[2])  cause = 32'h8000000B;
    else if (ip[1] & en[1])  cause = 32'h80000003;
    else                     cause = 32'h80000007;
    is_trap = valid & (exc | (ipend & ~fl[0]));
    is_mret = valid & ~exc & fl[0];
    tgt = vec & ~32'd3;
`ifdef EXCP_VECTORED_EN
    if (vec[1:0] == 2'b01 && !exc) tgt = tgt + 32'd4 * (cause & 32'h1F);
`endif
    ndrain = (busy < dto) ? busy : dto;
    err    = (busy > dto);

    if0.cmt_valid = valid; if0.cmt_pc = pc;
    {if0.cmt_ilgl, if0.cmt_ebreak, if0.cmt_ecall, if0.cmt_mret} = fl;
    {if0.ext_ip, if0.sft_ip, if0.tmr_ip} = ip;
    {if0.mstatus_mie, if0.meie, if0.msie, if0.mtie} = en;
    if0.lsu_idle = (busy == 0); if0.cmtvec = vec; if0.cmepc = ret; if0.redir_ready = 1'b0;
    #1;
    checks++;
    if (ctl !== {is_trap, valid & ~is_trap, 5'b00000}) begin
      failures++; $display("FAIL event_ctl got=%b exp=%b", ctl, {is_trap, valid & ~is_trap, 5'b00000});
    end
    checks++;
    if (o_cause !== exp_cause || o_epc !== exp_epc) begin
      failures++; $display("FAIL hold_cause got=%h/%h exp=%h/%h", o_cause, o_epc, exp_cause, exp_epc);
    end
    tick();
    if0.cmt_valid = 1'b0;
    {if0.cmt_ilgl, if0.cmt_ebreak, if0.cmt_ecall, if0.cmt_mret} = 4'b0000;

    if (is_trap) begin
      exp_cause = cause; exp_epc = pc;
      for (int k = 1; k <= ndrain; k++) begin
        if0.lsu_idle = (k >= busy);
        #1;
        checks++;
        if (ctl !== 7'b0010000) begin
          failures++; $display("FAIL drain_ctl cyc=%0d got=%b exp=%b", k, ctl, 7'b0010000);
        end
        tick();
      end
      if0.lsu_idle = 1'b1;
      #1;
      checks++;
      if (ctl !== {6'b001100, err} || o_cause !== cause || o_epc !== pc) begin
        failures++; $display("FAIL trap_cyc got=%b/%h/%h exp=%b/%h/%h", ctl, o_cause, o_epc, {6'b001100, err}, cause, pc);
      end
      tick();
    end else if (is_mret) begin
      #1;
      checks++;
      if (ctl !== 7'b0010100) begin
        failures++; $display("FAIL mret_cyc got=%b exp=%b", ctl, 7'b0010100);
      end
      tick();
      tgt = ret;
    end

    if (is_trap || is_mret) begin
      for (int r = 0; r <= rdly; r++) begin
        if0.redir_ready = (r == rdly);
        if0.cmtvec = $urandom; if0.cmepc = $urandom;
        #1;
        checks++;
        if (ctl !== 7'b0010010 || o_rpc !== tgt) begin
          failures++; $display("FAIL redir cyc=%0d got=%b/%h exp=%b/%h", r, ctl, o_rpc, 7'b0010010, tgt);
        end
        tick();
      end
      if0.redir_ready = 1'b0;
      #1;
      checks++;
      if (ctl !== 7'b0000000) begin
        failures++; $display("FAIL post_redir got=%b exp=%b", ctl, 7'b0000000);
      end
      tick();
    end
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++;
    if (ctl !== 7'b0 || o_cause !== 32'd0 || o_epc !== 32'd0 || o_rpc !== 32'd0) begin
      failures++; $display("FAIL reset got=%b/%h/%h/%h exp=0", ctl, o_cause, o_epc, o_rpc);
    end
    tick();
  endtask

  task automatic test_ecall;
    run_txn(1'b1, 32'h100, 4'b0010, 3'b000, 4'b0000, 32'h200, 32'h0, 0, 0);
  endtask

  task automatic test_drain_int;
    run_txn(1'b1, 32'h180, 4'b0000, 3'b001, 4'b1001, 32'h400, 32'h0, 5, 1);
    run_txn(1'b1, 32'h184, 4'b0000, 3'b001, 4'b0001, 32'h400, 32'h0, 5, 1);
  endtask

  task automatic test_priority;
    run_txn(1'b1, 32'h300, 4'b1000, 3'b111, 4'b1111, 32'h500, 32'h0, 0, 0);
    run_txn(1'b1, 32'h304, 4'b0000, 3'b111, 4'b1111, 32'h500, 32'h0, 0, 0);
    run_txn(1'b1, 32'h308, 4'b0001, 3'b111, 4'b1111, 32'h500, 32'h3C0, 0, 0);
  endtask

  task automatic test_mret;
    run_txn(1'b1, 32'h40, 4'b0001, 3'b000, 4'b0000, 32'h200, 32'h3C0, 0, 3);
  endtask

  task automatic test_vectored;
    run_txn(1'b1, 32'h60, 4'b0000, 3'b010, 4'b1010, 32'h201, 32'h0, 0, 0);
    run_txn(1'b1, 32'h64, 4'b0100, 3'b010, 4'b1010, 32'h201, 32'h0, 0, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 300; n++) begin
      run_txn(($urandom_range(0, 7) != 0), $urandom & ~32'd3,
              {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0)},
              3'($urandom), {($urandom_range(0, 3) != 0), 3'($urandom)},
              $urandom, $urandom, $urandom_range(0, 6), $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 6; n++) begin
      run_txn(1'b1, 32'h800 + 32'(n * 4), 4'b0010, 3'b000, 4'b0000, 32'h900, 32'h0, 0, 0);
      run_txn(1'b1, 32'h880 + 32'(n * 4), 4'b0000, 3'b000, 4'b0000, 32'h900, 32'h0, 0, 0);
    end
  endtask

  task automatic test_reset_midtrap;
    // Reset while the redirect is pending.
    run_txn(1'b1, 32'hA00, 4'b0000, 3'b000, 4'b0000, 32'h0, 32'h0, 0, 0);
    if0.cmt_valid = 1'b1; if0.cmt_pc = 32'hA04; if0.cmt_ecall = 1'b1;
    if0.lsu_idle = 1'b1; if0.cmtvec = 32'hB00;
    tick();
    if0.cmt_valid = 1'b0; if0.cmt_ecall = 1'b0;
    tick();
    #1;
    checks++;
    if (ctl !== 7'b0010010) begin
      failures++; $display("FAIL pre_reset_redir got=%b exp=%b", ctl, 7'b0010010);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b0 || o_rpc !== 32'd0) begin
      failures++; $display("FAIL reset_redir got=%b/%h exp=0/0", ctl, o_rpc);
    end
    exp_cause = 32'd0; exp_epc = 32'd0;
    tick();
    // Reset while draining: the trap must never reach the CSR file.
    if0.cmt_valid = 1'b1; if0.cmt_pc = 32'hA08; if0.cmt_ilgl = 1'b1; if0.lsu_idle = 1'b0;
    tick();
    if0.cmt_valid = 1'b0; if0.cmt_ilgl = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; if0.lsu_idle = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ctl !== 7'b0 || o_cause !== 32'd0) begin
        failures++; $display("FAIL reset_drain cyc=%0d got=%b/%h exp=0/0", k, ctl, o_cause);
      end
      tick();
    end
  endtask

  task automatic test_drain_timeout;
    sel4 = 1'b1;
    do_reset();
    run_txn(1'b1, 32'hC00, 4'b0010, 3'b000, 4'b0000, 32'hD00, 32'h0, 1000, 0);
    run_txn(1'b1, 32'hC04, 4'b0100, 3'b000, 4'b0000, 32'hD00, 32'h0, 4, 1);
    run_txn(1'b1, 32'hC08, 4'b0000, 3'b100, 4'b1100, 32'hD00, 32'h0, 5, 0);
    sel4 = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; sel4 = 1'b0; rst_n = 1'b0;
    exp_cause = 32'd0; exp_epc = 32'd0;
    test_reset();
    test_ecall();
    test_drain_int();
    test_priority();
    test_mret();
    test_vectored();
    test_random();
    test_back_to_back();
    test_reset_midtrap();
    test_drain_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
